// File: rtl/mger_pkg.sv
// Shared types, constants and helper functions for the MGER error-recovery output stage.
package mger_pkg;

    localparam int WIDTH        = 16;
    localparam int LSB_PASS     = 5;
    localparam int N_GROUPS     = 4;
    localparam int GRP_LAST_BIT = 11;
    localparam int TAIL_LSB     = 12;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'd0,
        MODE_FULL    = 2'd1,
        MODE_PARTIAL = 2'd2,
        MODE_RSVD    = 2'd3
    } mger_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GRP  = 2'd1,
        ST_TAIL = 2'd2,
        ST_OUT  = 2'd3
    } mger_state_e;

    // Clamp a requested group count to the number of groups that exist.
    function automatic logic [2:0] sat_groups(input logic [2:0] groups);
        logic [2:0] res;
        if (groups > 3'd4) begin
            res = 3'd4;
        end else begin
            res = groups;
        end
        return res;
    endfunction

    // Reserved mode behaves exactly like bypass.
    function automatic logic is_bypass(input mger_mode_e mode);
        logic res;
        case (mode)
            MODE_FULL:    res = 1'b0;
            MODE_PARTIAL: res = 1'b0;
            default:      res = 1'b1;
        endcase
        return res;
    endfunction

    // Mask of error bits that take part in recovery. Groups are cumulative
    // from the LSB end: {5,6}, {7,8}, {9,10}, {11}.
    function automatic logic [WIDTH-1:0] recovery_mask(input mger_mode_e mode,
                                                       input logic [2:0] groups);
        logic [WIDTH-1:0] mask;
        case (mode)
            MODE_FULL: begin
                mask = 16'h0FE0;
            end
            MODE_PARTIAL: begin
                case (groups)
                    3'd0:    mask = 16'h0000;
                    3'd1:    mask = 16'h0060;
                    3'd2:    mask = 16'h01E0;
                    3'd3:    mask = 16'h07E0;
                    default: mask = 16'h0FE0;
                endcase
            end
            default: begin
                mask = 16'h0000;
            end
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mger_group_step.sv
// One recovery group: a 2-bit adder of sum and error bits with carry chaining.
// When u_en is low the upper (u) bit is absent and the carry comes out of bit v.
module mger_group_step (
    input  logic s_u,
    input  logic s_v,
    input  logic e_u,
    input  logic e_v,
    input  logic c_in,
    input  logic u_en,
    output logic z_u,
    output logic z_v,
    output logic c_out
);

    logic       s_u_s;
    logic       e_u_s;
    logic [2:0] sum_s;

    // Add the group operands; route the carry from bit 1 or bit 2 depending on group width.
    always_comb begin
        s_u_s = 1'b0;
        e_u_s = 1'b0;
        if (u_en) begin
            s_u_s = s_u;
            e_u_s = e_u;
        end else begin
            s_u_s = 1'b0;
            e_u_s = 1'b0;
        end
        sum_s = {1'b0, s_u_s, s_v} + {1'b0, e_u_s, e_v} + {2'b00, c_in};
        z_v   = sum_s[0];
        if (u_en) begin
            z_u   = sum_s[1];
            c_out = sum_s[2];
        end else begin
            z_u   = 1'b0;
            c_out = sum_s[1];
        end
    end

endmodule

// File: rtl/mger_recovery_ctrl.sv
// Sequential error-recovery controller for the MGER approximate multiplier.
// Recovers bits 5..11 one group per cycle, then ripples the carry through 12..15.
module mger_recovery_ctrl
    import mger_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_mode,
    input  logic [2:0]       cfg_groups,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic [WIDTH-1:0] in_e,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_carry,
    output logic             busy
);

    mger_state_e             state_r;
    mger_mode_e              mode_r;
    logic [2:0]              groups_r;
    logic [1:0]              grp_cnt_r;
    logic                    carry_r;
    logic [WIDTH-1:0]        s_r;
    logic [WIDTH-1:0]        eeff_r;
    logic [GRP_LAST_BIT:0]   acc_r;
    logic [WIDTH-1:0]        out_z_r;
    logic                    out_carry_r;
    logic                    out_valid_r;
    logic                    cfg_err_r;
    logic                    in_ready_r;
    logic                    busy_r;

    mger_mode_e              mode_nxt_s;
    logic [2:0]              groups_nxt_s;
    logic                    bypass_nxt_s;
    logic [WIDTH-1:0]        eeff_nxt_s;
    logic [3:0]              v_idx_s;
    logic [3:0]              u_idx_s;
    logic                    u_en_s;
    logic                    s_u_s;
    logic                    s_v_s;
    logic                    e_u_s;
    logic                    e_v_s;
    logic                    z_u_s;
    logic                    z_v_s;
    logic                    c_out_s;
    logic [WIDTH-TAIL_LSB:0] tail_sum_s;

    // Configuration seen by an operand accepted this cycle: a same-cycle write wins.
    always_comb begin
        mode_nxt_s   = mode_r;
        groups_nxt_s = groups_r;
        if (cfg_we) begin
            mode_nxt_s   = mger_mode_e'(cfg_mode);
            groups_nxt_s = sat_groups(cfg_groups);
        end else begin
            mode_nxt_s   = mode_r;
            groups_nxt_s = groups_r;
        end
        bypass_nxt_s = is_bypass(mode_nxt_s);
        eeff_nxt_s   = in_e & recovery_mask(mode_nxt_s, groups_nxt_s);
    end

    // Select the bit pair handled by the current group; the last group has no u bit.
    always_comb begin
        u_en_s  = (grp_cnt_r != 2'(N_GROUPS - 1));
        v_idx_s = 4'(LSB_PASS) + {1'b0, grp_cnt_r, 1'b0};
        if (u_en_s) begin
            u_idx_s = v_idx_s + 4'd1;
        end else begin
            u_idx_s = v_idx_s;
        end
        s_v_s = s_r[v_idx_s];
        e_v_s = eeff_r[v_idx_s];
        s_u_s = s_r[u_idx_s];
        e_u_s = eeff_r[u_idx_s];
    end

    mger_group_step u_step (
        .s_u   (s_u_s),
        .s_v   (s_v_s),
        .e_u   (e_u_s),
        .e_v   (e_v_s),
        .c_in  (carry_r),
        .u_en  (u_en_s),
        .z_u   (z_u_s),
        .z_v   (z_v_s),
        .c_out (c_out_s)
    );

    // Final carry ripple through the upper nibble; only the group carry is added there.
    always_comb begin
        tail_sum_s = {1'b0, s_r[WIDTH-1:TAIL_LSB]} + {{(WIDTH - TAIL_LSB){1'b0}}, carry_r};
    end

    // Control FSM with operand, working and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            mode_r      <= MODE_BYPASS;
            groups_r    <= 3'd4;
            grp_cnt_r   <= 2'd0;
            carry_r     <= 1'b0;
            s_r         <= 16'h0000;
            eeff_r      <= 16'h0000;
            acc_r       <= 12'h000;
            out_z_r     <= 16'h0000;
            out_carry_r <= 1'b0;
            out_valid_r <= 1'b0;
            cfg_err_r   <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            cfg_err_r <= cfg_we && (state_r != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (cfg_we) begin
                        mode_r   <= mode_nxt_s;
                        groups_r <= groups_nxt_s;
                    end
                    if (in_valid) begin
                        s_r        <= in_s;
                        eeff_r     <= eeff_nxt_s;
                        acc_r      <= in_s[GRP_LAST_BIT:0];
                        grp_cnt_r  <= 2'd0;
                        carry_r    <= 1'b0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (bypass_nxt_s) begin
                            state_r     <= ST_OUT;
                            out_z_r     <= in_s;
                            out_carry_r <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r <= ST_GRP;
                        end
                    end
                end
                ST_GRP: begin
                    acc_r[v_idx_s] <= z_v_s;
                    if (u_en_s) begin
                        acc_r[u_idx_s] <= z_u_s;
                    end
                    carry_r   <= c_out_s;
                    grp_cnt_r <= grp_cnt_r + 2'd1;
                    if (grp_cnt_r == 2'(N_GROUPS - 1)) begin
                        state_r <= ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    out_z_r     <= {tail_sum_s[WIDTH-TAIL_LSB-1:0], acc_r};
                    out_carry_r <= tail_sum_s[WIDTH-TAIL_LSB];
                    out_valid_r <= 1'b1;
                    state_r     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_err   = cfg_err_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_z     = out_z_r;
    assign out_carry = out_carry_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mger_recovery_ctrl.sv
// Self-checking bench for mger_recovery_ctrl: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mger_recovery_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_mode;
    logic [2:0]  cfg_groups;
    logic        cfg_err;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_s;
    logic [15:0] in_e;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_z;
    logic        out_carry;
    logic        busy;

    int chk_cnt = 0;
    int err_cnt = 0;
    int model_mode = 0;
    int model_groups = 4;

    always #5 clk = ~clk;

    mger_recovery_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_mode   (cfg_mode),
        .cfg_groups (cfg_groups),
        .cfg_err    (cfg_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .in_e       (in_e),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_carry  (out_carry),
        .busy       (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: bit b in 5..11 belongs to group (b-5)/2; only groups below the
    // enabled count contribute their error bit, then Z = S + Eeff (17 bits).
    function automatic logic [16:0] ref_result(input int mode, input int groups,
                                               input logic [15:0] s, input logic [15:0] e);
        logic [15:0] eeff;
        int ng;
        eeff = 16'h0000;
        if (mode == 1) ng = 4;
        else if (mode == 2) ng = (groups > 4) ? 4 : groups;
        else ng = 0;
        for (int b = 5; b <= 11; b++) begin
            if ((b - 5) / 2 < ng) eeff[b] = e[b];
        end
        if (mode == 1 || mode == 2) return {1'b0, s} + {1'b0, eeff};
        return {1'b0, s};
    endfunction

    task automatic run_op(input bit wr, input int mode, input int groups,
                          input logic [15:0] s, input logic [15:0] e,
                          input int stall, input int poke);
        logic [16:0] expv;
        int n;
        int lat_exp;
        check_val("in_ready_idle", in_ready, 1);
        if (wr) begin
            model_mode   = mode;
            model_groups = groups;
        end
        expv    = ref_result(model_mode, model_groups, s, e);
        lat_exp = (model_mode == 1 || model_mode == 2) ? 6 : 1;
        cfg_we     = wr;
        cfg_mode   = 2'(mode);
        cfg_groups = 3'(groups);
        in_valid   = 1'b1;
        in_s       = s;
        in_e       = e;
        tick;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            in_valid = 1'($urandom_range(0, 1));
            in_s     = 16'($urandom);
            in_e     = 16'($urandom);
            if (poke != 0 && n == poke) begin
                cfg_we     = 1'b1;
                cfg_mode   = 2'd0;
                cfg_groups = 3'd0;
            end
            tick;
            cfg_we = 1'b0;
            n++;
            if (poke != 0 && n == poke + 1) check_val("cfg_err_pulse", cfg_err, 1);
            if (poke != 0 && n == poke + 2) check_val("cfg_err_clear", cfg_err, 0);
        end
        check_val("latency", n, lat_exp);
        check_val("out_z", out_z, expv[15:0]);
        check_val("out_carry", out_carry, expv[16]);
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            tick;
            check_val("hold_z", out_z, expv[15:0]);
            check_val("hold_valid", out_valid, 1);
            check_val("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check_val("post_valid", out_valid, 0);
        check_val("post_in_ready", in_ready, 1);
        check_val("post_busy", busy, 0);
        check_val("post_z_hold", out_z, expv[15:0]);
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_we     = 1'b0;
        cfg_mode   = 2'd0;
        cfg_groups = 3'd0;
        in_valid   = 1'b0;
        in_s       = 16'h0000;
        in_e       = 16'h0000;
        out_ready  = 1'b0;
        tick;
        tick;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_out_z", out_z, 0);
        check_val("rst_out_carry", out_carry, 0);
        check_val("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        tick;

        // Directed cases
        run_op(1'b1, 1, 4, 16'h0000, 16'h0FE0, 0, 0);
        run_op(1'b1, 1, 4, 16'h0FE0, 16'h0020, 0, 0);
        run_op(1'b1, 1, 4, 16'hFFE0, 16'h0020, 0, 0);
        run_op(1'b1, 2, 1, 16'h0060, 16'h0FE0, 0, 0);
        run_op(1'b0, 2, 1, 16'h0060, 16'hFFFF, 0, 0);
        run_op(1'b1, 0, 4, 16'h0060, 16'h0FE0, 0, 0);
        run_op(1'b1, 3, 4, 16'h0060, 16'hFFFF, 0, 0);
        run_op(1'b1, 2, 7, 16'h0FFF, 16'h0FFF, 0, 0);
        // Backpressure plus a rejected config write during GRP; FULL must persist
        run_op(1'b1, 1, 4, 16'h0123, 16'h0AA0, 5, 2);
        run_op(1'b0, 0, 0, 16'hF0F0, 16'h0FE0, 0, 0);

        // Reset in the middle of group 2 aborts and restores BYPASS
        cfg_we     = 1'b1;
        cfg_mode   = 2'd1;
        cfg_groups = 3'd4;
        in_valid   = 1'b1;
        in_s       = 16'h1234;
        in_e       = 16'h0FE0;
        tick;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        tick;
        tick;
        check_val("busy_in_grp", busy, 1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        model_mode   = 0;
        model_groups = 4;
        check_val("abort_busy", busy, 0);
        check_val("abort_out_valid", out_valid, 0);
        check_val("abort_in_ready", in_ready, 1);
        check_val("abort_out_z", out_z, 0);
        run_op(1'b0, 0, 0, 16'h1234, 16'h0FE0, 0, 0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 3)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
